// File: rtl/dbus_demux.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_demux
//  Purpose  : Data-bus demultiplexer between the core data port and up to
//             eight memory-mapped targets. Each target owns a mask/base
//             address region. Read responses are routed back to the host by
//             tracking which target owns the reads still in flight. An access
//             that hits no region gets an error response one cycle later, so
//             the core never hangs.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock, asynchronous active-high reset
//    h_req             host request
//    h_write           1 = write, 0 = read
//    h_wstrb           byte strobes (DW/8)
//    h_addr            byte address
//    h_wdata           write data
//    h_ready           request accepted this cycle when h_req & h_ready
//    h_rvalid          read response valid
//    h_rdata           read data (zero when h_rvalid = 0)
//    h_err             decode-error pulse, one cycle after acceptance
//    t_req             per-target request
//    t_write/t_wstrb/t_addr/t_wdata   broadcast copies of the host fields
//    t_ready           per-target ready
//    t_rvalid          per-target read valid
//    t_rdata           per-target read data, target i at [i*DW +: DW]
// ============================================================================
module dbus_demux #(
  parameter int              NT              = 2,
  parameter int              AW              = 32,
  parameter int              DW              = 32,
  parameter int              MAX_OUTSTANDING = 4,
  parameter logic [NT*AW-1:0] T_BASE         = {32'h2000_0000, 32'h0000_0000},
  parameter logic [NT*AW-1:0] T_MASK         = {32'hF000_0000, 32'hE000_0000},
  parameter logic [DW-1:0]   ERR_DATA        = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  // host side
  input  logic               h_req,
  input  logic               h_write,
  input  logic [DW/8-1:0]    h_wstrb,
  input  logic [AW-1:0]      h_addr,
  input  logic [DW-1:0]      h_wdata,
  output logic               h_ready,
  output logic               h_rvalid,
  output logic [DW-1:0]      h_rdata,
  output logic               h_err,
  // target side
  output logic [NT-1:0]      t_req,
  output logic               t_write,
  output logic [DW/8-1:0]    t_wstrb,
  output logic [AW-1:0]      t_addr,
  output logic [DW-1:0]      t_wdata,
  input  logic [NT-1:0]      t_ready,
  input  logic [NT-1:0]      t_rvalid,
  input  logic [NT*DW-1:0]   t_rdata
);

  // Counter must hold 0..MAX_OUTSTANDING; target index must hold 0..NT,
  // where NT is the error pseudo-target.
  localparam int            CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int            IW        = $clog2(NT + 1);
  localparam logic [IW-1:0] c_ERR_IDX = IW'(NT);
  localparam logic [CW-1:0] c_CNT_MAX = CW'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;       // accepted-but-unanswered reads
  logic [IW-1:0] r_cur;       // target owning the outstanding reads
  logic          r_err_pend;  // error response due this cycle
  logic          r_err_rd;    // the pending error was a read

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NT-1:0] w_hit;
  logic [IW-1:0] w_sel;
  logic          w_sel_ready;
  logic          w_cur_rvalid;
  logic [DW-1:0] w_cur_rdata;
  logic          w_stall;
  logic          w_accept;
  logic          w_rd_accept;
  logic          w_route;
  logic          w_err_rsp;

  // Broadcast host fields; only t_req is steered.
  assign t_write = h_write;
  assign t_wstrb = h_wstrb;
  assign t_addr  = h_addr;
  assign t_wdata = h_wdata;

  // Region hit per target.
  generate
    for (genvar gi = 0; gi < NT; gi++) begin : g_hit
      assign w_hit[gi] = ((h_addr & T_MASK[gi*AW +: AW]) == T_BASE[gi*AW +: AW]);
    end
  endgenerate

  // Priority decode: scan from the top down so the lowest hitting index is
  // the last to assign and therefore wins. No hit leaves the ERR index.
  always_comb begin
    w_sel = c_ERR_IDX;
    for (int i = NT - 1; i >= 0; i--) begin
      if (w_hit[i]) w_sel = IW'(i);
    end
  end

  // Ready of the decoded target. The ERR pseudo-target is always ready.
  always_comb begin
    w_sel_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      if (w_sel == IW'(i)) w_sel_ready = t_ready[i];
    end
  end

  // Response of the target owning the outstanding reads. When r_cur is the
  // ERR index no real target matches, so nothing is routed.
  always_comb begin
    w_cur_rvalid = 1'b0;
    w_cur_rdata  = '0;
    for (int i = 0; i < NT; i++) begin
      if (r_cur == IW'(i)) begin
        w_cur_rvalid = t_rvalid[i];
        w_cur_rdata  = t_rdata[i*DW +: DW];
      end
    end
  end

  // Reads must come back in issue order, so a request to a different target
  // waits until every outstanding read has been answered. An error in flight
  // also blocks the port for its single response cycle.
  assign w_stall = (r_cnt == c_CNT_MAX)
                || ((r_cnt != '0) && (w_sel != r_cur))
                || r_err_pend;

  assign h_ready = !w_stall && w_sel_ready;

  always_comb begin
    t_req = '0;
    for (int i = 0; i < NT; i++) begin
      t_req[i] = h_req && !w_stall && (w_sel == IW'(i));
    end
  end

  assign w_accept    = h_req && h_ready;
  assign w_rd_accept = w_accept && !h_write;

  // Target responses only count while reads are outstanding; stray or late
  // rvalids are dropped.
  assign w_route   = (r_cnt != '0) && w_cur_rvalid;
  assign w_err_rsp = r_err_pend && r_err_rd;

  assign h_rvalid = w_route || w_err_rsp;
  assign h_err    = r_err_pend;

  always_comb begin
    h_rdata = '0;
    if (w_route)        h_rdata = w_cur_rdata;
    else if (w_err_rsp) h_rdata = ERR_DATA;
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_err_pend <= 1'b0;
      r_err_rd   <= 1'b0;
    end else begin
      // Increment cannot hit full (stall blocks it) and decrement only
      // happens on a response, which needs r_cnt != 0: no wrap either way.
      case ({w_rd_accept, h_rvalid})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_rd_accept) r_cur <= w_sel;

      // Nothing is accepted while r_err_pend is set, so set and clear
      // never collide.
      if (w_accept && (w_sel == c_ERR_IDX)) begin
        r_err_pend <= 1'b1;
        r_err_rd   <= !h_write;
      end else if (r_err_pend) begin
        r_err_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbus_demux
//  Purpose  : Directed self-checking bench for dbus_demux with the default
//             two-target map (RAM at 0x0000_0000/E000_0000, GPIO at
//             0x2000_0000/F000_0000). Inputs change on the falling edge and
//             outputs are sampled 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_demux;

  localparam int NT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               h_req;
  logic               h_write;
  logic [DW/8-1:0]    h_wstrb;
  logic [AW-1:0]      h_addr;
  logic [DW-1:0]      h_wdata;
  logic               h_ready;
  logic               h_rvalid;
  logic [DW-1:0]      h_rdata;
  logic               h_err;
  logic [NT-1:0]      t_req;
  logic               t_write;
  logic [DW/8-1:0]    t_wstrb;
  logic [AW-1:0]      t_addr;
  logic [DW-1:0]      t_wdata;
  logic [NT-1:0]      t_ready;
  logic [NT-1:0]      t_rvalid;
  logic [NT*DW-1:0]   t_rdata;

  int n_vec     = 0;
  int n_miscmp  = 0;

  always #5 clk = ~clk;

  dbus_demux dut (
    .clk      (clk),
    .rst      (rst),
    .h_req    (h_req),
    .h_write  (h_write),
    .h_wstrb  (h_wstrb),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_ready  (h_ready),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .h_err    (h_err),
    .t_req    (t_req),
    .t_write  (t_write),
    .t_wstrb  (t_wstrb),
    .t_addr   (t_addr),
    .t_wdata  (t_wdata),
    .t_ready  (t_ready),
    .t_rvalid (t_rvalid),
    .t_rdata  (t_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge with the host and targets idle.
  task automatic idle_cycle();
    @(negedge clk);
    h_req    = 1'b0;
    h_write  = 1'b0;
    h_wstrb  = 4'h0;
    h_addr   = 32'h0;
    h_wdata  = 32'h0;
    t_ready  = 2'b11;
    t_rvalid = 2'b00;
    t_rdata  = '0;
  endtask

  // Idle cycle with a host request presented.
  task automatic req_cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    idle_cycle();
    h_req   = 1'b1;
    h_write = wr;
    h_wstrb = 4'hF;
    h_addr  = addr;
    h_wdata = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    h_req    = 1'b0;
    h_write  = 1'b0;
    h_wstrb  = 4'h0;
    h_addr   = 32'h0;
    h_wdata  = 32'h0;
    t_ready  = 2'b11;
    t_rvalid = 2'b00;
    t_rdata  = '0;

    // ---------------- reset state ----------------
    idle_cycle();
    idle_cycle();
    #1;
    check("rst_h_ready",  {31'b0, h_ready},  32'd1);
    check("rst_h_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("rst_h_rdata",  h_rdata,           32'h0);
    check("rst_h_err",    {31'b0, h_err},    32'd0);
    check("rst_t_req",    {30'b0, t_req},    32'd0);
    idle_cycle();
    rst = 1'b0;

    // ---------------- single-target read ----------------
    req_cycle(1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("rd0_t_req",   {30'b0, t_req},    32'h1);
    check("rd0_h_ready", {31'b0, h_ready},  32'd1);
    check("rd0_t_addr",  t_addr,            32'h0000_0010);
    idle_cycle();
    t_rvalid = 2'b01;
    t_rdata[31:0] = 32'h1234_5678;
    #1;
    check("rd0_h_rvalid", {31'b0, h_rvalid}, 32'd1);
    check("rd0_h_rdata",  h_rdata,           32'h1234_5678);
    check("rd0_h_err",    {31'b0, h_err},    32'd0);
    idle_cycle();
    #1;
    check("rd0_idle_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("rd0_idle_rdata",  h_rdata,           32'h0);

    // ---------------- region decode ----------------
    req_cycle(1'b1, 32'h2000_0004, 32'h0000_00A5);
    #1;
    check("wr1_t_req",   {30'b0, t_req},   32'h2);
    check("wr1_t_wdata", t_wdata,          32'h0000_00A5);
    check("wr1_t_write", {31'b0, t_write}, 32'd1);
    check("wr1_h_ready", {31'b0, h_ready}, 32'd1);
    // Target 0 accepted immediately: the write left cnt at 0.
    req_cycle(1'b0, 32'h1000_0000, 32'h0);
    #1;
    check("dec_1000_t_req",   {30'b0, t_req},   32'h1);
    check("dec_1000_h_ready", {31'b0, h_ready}, 32'd1);
    // Response cycle with a stray GPIO rvalid that must be ignored.
    idle_cycle();
    t_rvalid = 2'b11;
    t_rdata  = {32'h5A5A_5A5A, 32'hCAFE_0001};
    #1;
    check("dec_1000_rvalid", {31'b0, h_rvalid}, 32'd1);
    check("dec_1000_rdata",  h_rdata,           32'hCAFE_0001);

    // Target ready passes straight through to the host.
    req_cycle(1'b1, 32'h2000_0008, 32'h1);
    t_ready = 2'b01;
    #1;
    check("notrdy_h_ready", {31'b0, h_ready}, 32'd0);
    check("notrdy_t_req",   {30'b0, t_req},   32'h2);

    // ---------------- unmapped read ----------------
    req_cycle(1'b0, 32'h3000_0000, 32'h0);
    #1;
    check("err_rd_h_ready", {31'b0, h_ready}, 32'd1);
    check("err_rd_t_req",   {30'b0, t_req},   32'h0);
    // Error response cycle; a RAM write presented now must be held.
    req_cycle(1'b1, 32'h0000_0000, 32'h77);
    #1;
    check("err_rd_rvalid",   {31'b0, h_rvalid}, 32'd1);
    check("err_rd_rdata",    h_rdata,           32'hDEAD_BEEF);
    check("err_rd_h_err",    {31'b0, h_err},    32'd1);
    check("err_hold_ready",  {31'b0, h_ready},  32'd0);
    check("err_hold_t_req",  {30'b0, t_req},    32'h0);
    req_cycle(1'b1, 32'h0000_0000, 32'h77);
    #1;
    check("err_after_h_err",  {31'b0, h_err},    32'd0);
    check("err_after_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("err_after_ready",  {31'b0, h_ready},  32'd1);
    check("err_after_t_req",  {30'b0, t_req},    32'h1);

    // ---------------- unmapped write ----------------
    req_cycle(1'b1, 32'h4000_0000, 32'h0);
    #1;
    check("err_wr_h_ready", {31'b0, h_ready}, 32'd1);
    check("err_wr_t_req",   {30'b0, t_req},   32'h0);
    idle_cycle();
    #1;
    check("err_wr_h_err",  {31'b0, h_err},    32'd1);
    check("err_wr_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("err_wr_rdata",  h_rdata,           32'h0);
    idle_cycle();
    #1;
    check("err_wr_clear", {31'b0, h_err}, 32'd0);

    // ---------------- outstanding limit ----------------
    // Reads issued at c0..c3; the first answer comes at c10.
    for (int c = 0; c < 4; c++) begin
      req_cycle(1'b0, 32'h0000_0100, 32'h0);
      #1;
      check("lim_accept", {31'b0, h_ready}, 32'd1);
    end
    for (int c = 4; c < 10; c++) begin
      req_cycle(1'b0, 32'h0000_0100, 32'h0);
      #1;
      check("lim_full_ready", {31'b0, h_ready}, 32'd0);
      check("lim_full_t_req", {30'b0, t_req},   32'h0);
    end
    req_cycle(1'b0, 32'h0000_0100, 32'h0);
    t_rvalid = 2'b01;
    t_rdata[31:0] = 32'h0000_00A0;
    #1;
    check("lim_rsp0_rvalid", {31'b0, h_rvalid}, 32'd1);
    check("lim_rsp0_rdata",  h_rdata,           32'h0000_00A0);
    check("lim_rsp0_ready",  {31'b0, h_ready},  32'd0);
    req_cycle(1'b0, 32'h0000_0100, 32'h0);
    #1;
    check("lim_5th_ready", {31'b0, h_ready}, 32'd1);
    check("lim_5th_t_req", {30'b0, t_req},   32'h1);
    for (int c = 1; c <= 4; c++) begin
      idle_cycle();
      t_rvalid = 2'b01;
      t_rdata[31:0] = 32'h0000_00A0 + c;
      #1;
      check("lim_drain_rvalid", {31'b0, h_rvalid}, 32'd1);
      check("lim_drain_rdata",  h_rdata,           32'h0000_00A0 + c);
    end
    // All answered: a further rvalid is dropped.
    idle_cycle();
    t_rvalid = 2'b01;
    t_rdata[31:0] = 32'h0000_00FF;
    #1;
    check("lim_extra_rvalid", {31'b0, h_rvalid}, 32'd0);

    // ---------------- cross-target ordering ----------------
    req_cycle(1'b0, 32'h0000_0200, 32'h0);
    #1;
    check("x_ram_ready", {31'b0, h_ready}, 32'd1);
    req_cycle(1'b0, 32'h2000_0000, 32'h0);
    t_rvalid = 2'b10;
    t_rdata  = {32'h5555_5555, 32'h0};
    #1;
    check("x_hold_ready",  {31'b0, h_ready},  32'd0);
    check("x_hold_t_req",  {30'b0, t_req},    32'h0);
    check("x_spur_rvalid", {31'b0, h_rvalid}, 32'd0);
    for (int c = 2; c < 5; c++) begin
      req_cycle(1'b0, 32'h2000_0000, 32'h0);
      #1;
      check("x_hold_ready", {31'b0, h_ready}, 32'd0);
    end
    req_cycle(1'b0, 32'h2000_0000, 32'h0);
    t_rvalid = 2'b01;
    t_rdata  = {32'h0, 32'h1111_1111};
    #1;
    check("x_ram_rvalid", {31'b0, h_rvalid}, 32'd1);
    check("x_ram_rdata",  h_rdata,           32'h1111_1111);
    check("x_ram_ready0", {31'b0, h_ready},  32'd0);
    req_cycle(1'b0, 32'h2000_0000, 32'h0);
    #1;
    check("x_gpio_ready", {31'b0, h_ready}, 32'd1);
    check("x_gpio_t_req", {30'b0, t_req},   32'h2);
    idle_cycle();
    t_rvalid = 2'b10;
    t_rdata  = {32'h2222_2222, 32'h0};
    #1;
    check("x_gpio_rvalid", {31'b0, h_rvalid}, 32'd1);
    check("x_gpio_rdata",  h_rdata,           32'h2222_2222);
    idle_cycle();
    #1;
    check("x_idle_rvalid", {31'b0, h_rvalid}, 32'd0);

    // ---------------- reset mid-flight ----------------
    for (int c = 0; c < 3; c++) begin
      req_cycle(1'b0, 32'h0000_0300, 32'h0);
      #1;
      check("rm_accept", {31'b0, h_ready}, 32'd1);
    end
    idle_cycle();
    rst = 1'b1;
    #1;
    check("rm_h_ready",  {31'b0, h_ready},  32'd1);
    check("rm_h_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("rm_h_rdata",  h_rdata,           32'h0);
    check("rm_h_err",    {31'b0, h_err},    32'd0);
    check("rm_t_req",    {30'b0, t_req},    32'h0);
    idle_cycle();
    rst = 1'b0;
    // Late RAM answer is dropped; GPIO request is not held by stale state.
    req_cycle(1'b0, 32'h2000_0010, 32'h0);
    t_rvalid = 2'b01;
    t_rdata  = {32'h0, 32'h3333_3333};
    #1;
    check("rm_late_rvalid", {31'b0, h_rvalid}, 32'd0);
    check("rm_late_rdata",  h_rdata,           32'h0);
    check("rm_gpio_ready",  {31'b0, h_ready},  32'd1);
    check("rm_gpio_t_req",  {30'b0, t_req},    32'h2);
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbus_demux.md
# dbus_demux

Parametrised data-bus demultiplexer between the core's data port and up to eight memory-mapped targets such as data RAM, GPIO and timers. It is the successor to the fixed two-target decode in the SoC top level. It adds mask/base address regions and routes read responses by tracking outstanding reads instead of OR-ing target `rvalid`. Unmapped accesses receive an error response instead of hanging the core.

## Interface
- `NT`, 2: number of targets, 1..8.
- `AW`, 32: address width.
- `DW`, 32: data width; `wstrb` is `DW/8`.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unanswered reads, 1..15.
- `T_BASE`, `{NT*AW}` packed, default {32'h2000_0000, 32'h0000_0000}: region base, target i at `[i*AW +: AW]`.
- `T_MASK`, `{NT*AW}` packed, default {32'hF000_0000, 32'hE000_0000}: region mask; target i hits when `(addr & mask_i) == base_i`.
- `ERR_DATA`, 32'hDEAD_BEEF: `h_rdata` value on a decode-error read.

Ports:
- `clk` in 1: clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `h_req` in 1: host request.
- `h_write` in 1: 1 = write, 0 = read.
- `h_wstrb` in DW/8: byte strobes.
- `h_addr` in AW: byte address.
- `h_wdata` in DW: write data.
- `h_ready` out 1: request accepted this cycle when `h_req & h_ready`.
- `h_rvalid` out 1: read response valid.
- `h_rdata` out DW: read data.
- `h_err` out 1: decode-error flag, one-cycle pulse.
- `t_req` out NT: per-target request.
- `t_write`, `t_wstrb`, `t_addr`, `t_wdata` out: broadcast copies of the host fields.
- `t_ready` in NT: per-target ready.
- `t_rvalid` in NT: per-target read valid.
- `t_rdata` in NT*DW: per-target read data, target i at `[i*DW +: DW]`.

## Operation
- **Decode**
  - Combinational.
  - The lowest-index hitting target wins.
  - No hit gives the pseudo-target ERR (index NT).
- **State**
  - `cnt`: outstanding reads, width `$clog2(MAX_OUTSTANDING+1)`.
  - `cur`: target owning the outstanding reads, range 0..NT.
  - `err_pend`: 1 bit.
  - `err_rd`: 1 bit.
- **Stall.** `h_ready` = 0 when any of these holds:
  - `cnt == MAX_OUTSTANDING`;
  - `cnt != 0` and the decoded target ≠ `cur`;
  - `err_pend` = 1.
- **Not stalled, real target i:**
  - `t_req[i] = h_req`;
  - `h_ready = t_ready[i]`;
  - all other `t_req` bits are 0.
- **Not stalled, ERR:**
  - `h_ready` = 1 and no `t_req` is asserted;
  - acceptance sets `err_pend` and sets `err_rd = !h_write`;
  - a read also increments `cnt` and sets `cur = NT`.
- **Accepted read to target i:** `cnt` +1 and `cur` ← i. Writes never change `cnt`.
- **Response routing**
  - When `cnt != 0` and `cur < NT`: `h_rvalid = t_rvalid[cur]` and `h_rdata = t_rdata[cur]`.
  - A `t_rvalid` seen when `cnt == 0` is ignored, as is any `t_rvalid` from a target ≠ `cur`.
- **Error response**
  - In the cycle after ERR acceptance: `h_err` = 1 and `err_pend` clears.
  - For a read, that same cycle also has `h_rvalid` = 1, `h_rdata = ERR_DATA` and `cnt` −1.
- **Counter arithmetic**
  - Read acceptance and response in the same cycle leaves `cnt` unchanged.
  - `cnt` never wraps: increment is blocked at full, decrement only happens on a routed response.
- When `h_rvalid` = 0, `h_rdata` = 0.

## Timing
- **Reset values:** `h_ready` follows the combinational path with `cnt` = 0; `h_rvalid` = 0, `h_rdata` = 0, `h_err` = 0, `t_req` = 0, `cnt` = 0, `cur` = 0, `err_pend` = 0.
- **Zero added latency** on the request path: `h_ready` and `t_req` are combinational from `h_req`, `h_addr`, `t_ready` and state.
- **Response path is combinational.** Target read latency passes through unchanged, with a minimum of 1 cycle after acceptance.
- **Error response latency:** exactly 1 cycle after acceptance.
- **Back-to-back reads to the same target:** one per cycle until `cnt` reaches `MAX_OUTSTANDING`.
- **Switching targets:** the first request to a new target is accepted no earlier than the cycle in which the last response from the old target is returned (`cnt` → 0 that cycle; the comparison uses registered `cnt`, so acceptance is the next cycle).
- **Reset mid-operation:** all state clears immediately. Target responses that arrive after reset are dropped because `cnt` = 0.

## Test plan
- **Single-target read:**
  - Stimulus: read 0x0000_0010; RAM model answers `rvalid` 1 cycle later with 0x1234_5678.
  - Required: `t_req[0]` asserted, `h_rvalid` 1 cycle later with 0x1234_5678, `h_err` = 0.
- **Region decode:**
  - Stimulus: write 0x2000_0004 with data 0xA5.
  - Required: only `t_req[1]` asserted, `t_wdata` = 0xA5, `cnt` stays 0.
  - Stimulus: address 0x1000_0000.
  - Required: hits target 0 (mask E000_0000).
- **Unmapped read:**
  - Stimulus: read 0x3000_0000.
  - Required: `h_ready` = 1 with no `t_req`; next cycle `h_rvalid` = 1, `h_rdata` = 0xDEAD_BEEF, `h_err` = 1.
  - Stimulus: unmapped write.
  - Required: `h_err` pulse with no `h_rvalid`.
- **Outstanding limit:**
  - Stimulus: 5 consecutive reads to RAM with a 10-cycle response latency, `MAX_OUTSTANDING` = 4.
  - Required: 4 accepted; the 5th is stalled until the first response, then accepted.
- **Cross-target ordering:**
  - Stimulus: read RAM (latency 5), then read GPIO (latency 1) on the next cycle.
  - Required: the GPIO request is held (`h_ready` = 0) until the RAM response returns; responses reach the host in issue order; a spurious GPIO `t_rvalid` during the hold is ignored.
- **Reset mid-flight:**
  - Stimulus: assert `rst` with `cnt` = 3.
  - Required: `cnt` = 0 and all outputs at reset values; late RAM `rvalid` after deassertion produces no `h_rvalid`.
